// File: rtl/sweep_pkg.sv
// Shared types and widths for the operand sweep sequencer and its result FIFO.
package sweep_pkg;

    localparam int A_W   = 5;
    localparam int B_W   = 5;
    localparam int Y_W   = 3;
    localparam int IDX_W = A_W + B_W;
    localparam int N_VEC = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [Y_W-1:0] y;
        logic [Y_W-1:0] xe;
    } tuple_t;

endpackage

// File: rtl/operand_sweep_seq_if.sv
// Result stream from the sweep sequencer to its downstream logger/checker.
// Handshake: a tuple transfers on every rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// producer keeps out_valid and all out_* fields unchanged, and out_valid never
// depends combinationally on out_ready.
interface operand_sweep_seq_if;
    import sweep_pkg::*;

    logic           out_valid;
    logic           out_ready;
    logic [A_W-1:0] out_a;
    logic [B_W-1:0] out_b;
    logic [Y_W-1:0] out_y;
    logic [Y_W-1:0] out_xe;

    modport master (output out_valid, out_a, out_b, out_y, out_xe, input out_ready);
    modport slave  (input out_valid, out_a, out_b, out_y, out_xe, output out_ready);

endinterface

// File: rtl/sweep_fifo.sv
// Small synchronous FIFO of sweep tuples; head is read straight from storage.
module sweep_fifo
    import sweep_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  tuple_t                   push_data,
    input  logic                     pop,
    output tuple_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    tuple_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage, pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/operand_sweep_seq.sv
// Walks every (a,b) operand pair for the combinational block f, captures f's
// outputs alongside the operands and queues the tuples for a downstream reader.
module operand_sweep_seq
    import sweep_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    output logic [A_W-1:0]           a,
    output logic [B_W-1:0]           b,
    input  logic [Y_W-1:0]           y,
    input  logic [Y_W-1:0]           xe,
    operand_sweep_seq_if.master      out_if,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W:0]           pushed,
    output state_t                   dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W:0]    r_pushed;
    logic              r_busy;
    logic              r_done;

    logic              w_active;
    logic              w_start_ok;
    logic              w_abort;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    tuple_t            w_push_data;
    tuple_t            w_head;

    // Operands come straight from the index register: a is the low field.
    assign a = r_idx[A_W-1:0];
    assign b = r_idx[IDX_W-1:A_W];

    // stop beats start; start is only honoured outside a sweep.
    assign w_active    = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_ok  = start && !stop && !w_active;
    assign w_abort     = stop && w_active;
    assign w_flush     = w_abort || w_start_ok;
    // Push gating uses registered occupancy only, so a same-cycle pop never frees a slot.
    assign w_push      = (r_state == RUN) && !stop && !w_full;
    assign w_pop       = out_if.out_valid && out_if.out_ready;
    assign w_push_data = {a, b, y, xe};

    assign out_if.out_valid = !w_empty;
    assign out_if.out_a     = w_head.a;
    assign out_if.out_b     = w_head.b;
    assign out_if.out_y     = w_head.y;
    assign out_if.out_xe    = w_head.xe;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pushed    = r_pushed;
    assign dbg_state = r_state;

    sweep_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (dbg_count)
    );

    // Sequencer FSM with index/push counters and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_pushed <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state  <= RUN;
                        r_idx    <= '0;
                        r_pushed <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_push) begin
                        r_pushed <= r_pushed + (IDX_W+1)'(1);
                        if (r_idx == IDX_W'(N_VEC - 1)) begin
                            r_idx   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_empty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
